// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter_if
//  Description : Bundle of the fetch, load/store and RAM-side signals around
//                the RAM port arbiter.
//                  slave  - the arbiter's view (takes requests, drives RAM)
//                  master - the surrounding system's view (control unit and
//                           RAM: drives requests, ramDataOut and ramMFC)
//  Parameters  : ADDR_W - RAM address width
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 9
);
    // fetch path
    logic              fetchReq;
    logic [ADDR_W-1:0] fetchAddr;
    logic              fetchGnt;
    logic              fetchDone;
    // load/store path
    logic              dataReq;
    logic              dataRW;
    logic [1:0]        dataSize;
    logic [ADDR_W-1:0] dataAddr;
    logic [31:0]       dataWdata;
    logic              dataGnt;
    logic              dataDone;
    // shared results
    logic [31:0]       rdata;
    logic              busErr;
    // RAM side
    logic              ramMFA;
    logic              ramRW;
    logic [ADDR_W-1:0] ramAddress;
    logic [1:0]        ramDataSize;
    logic [31:0]       ramDataIn;
    logic [31:0]       ramDataOut;
    logic              ramMFC;

    modport slave (
        input  fetchReq, fetchAddr,
        input  dataReq, dataRW, dataSize, dataAddr, dataWdata,
        input  ramDataOut, ramMFC,
        output fetchGnt, fetchDone, dataGnt, dataDone, rdata, busErr,
        output ramMFA, ramRW, ramAddress, ramDataSize, ramDataIn
    );

    modport master (
        output fetchReq, fetchAddr,
        output dataReq, dataRW, dataSize, dataAddr, dataWdata,
        output ramDataOut, ramMFC,
        input  fetchGnt, fetchDone, dataGnt, dataDone, rdata, busErr,
        input  ramMFA, ramRW, ramAddress, ramDataSize, ramDataIn
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Shares the single RAM port between instruction fetch and the
//                load/store path. Runs the MFA/MFC handshake for the winner,
//                returns read data, and aborts an access with a one-cycle
//                busErr pulse if ramMFC does not arrive within TIMEOUT cycles.
//  Ports       : Clk    - clock, rising edge
//                resetN - asynchronous active-low reset
//                bus    - ram_port_arbiter_if.slave (fetch, data, RAM signals)
//  Parameters  : TIMEOUT (2..255) - BUSY cycles allowed before abort
//                ADDR_W           - RAM address width (must match bus)
//  Build macro : RAM_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests
//                alternate owners; otherwise data always beats fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 9
) (
    input  logic              Clk,
    input  logic              resetN,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        timer_q, timer_d;
    logic              owner_q, owner_d;      // 1 = data path, 0 = fetch
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mfa_q, mfa_d;
    logic              fgnt_q, fgnt_d;
    logic              dgnt_q, dgnt_d;
    logic              fdone_q, fdone_d;
    logic              ddone_q, ddone_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              w_pick_data;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic              last_owner_q, last_owner_d;   // 1 = data granted last
    // On a tie, whoever was not granted last wins.
    assign w_pick_data = bus.dataReq && !(bus.fetchReq && last_owner_q);
`else
    assign w_pick_data = bus.dataReq;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        owner_d = owner_q;
        rw_d    = rw_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mfa_d   = mfa_q;
        fgnt_d  = fgnt_q;
        dgnt_d  = dgnt_q;
        fdone_d = 1'b0;
        ddone_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.dataReq || bus.fetchReq) begin
                    owner_d = w_pick_data;
                    if (w_pick_data) begin
                        rw_d    = bus.dataRW;
                        size_d  = bus.dataSize;
                        addr_d  = bus.dataAddr;
                        wdata_d = bus.dataWdata;
                        dgnt_d  = 1'b1;
                    end else begin
                        // Fetches are always word reads.
                        rw_d    = 1'b0;
                        size_d  = 2'b11;
                        addr_d  = bus.fetchAddr;
                        wdata_d = 32'd0;
                        fgnt_d  = 1'b1;
                    end
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    last_owner_d = w_pick_data;
`endif
                    mfa_d   = 1'b1;
                    timer_d = 8'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // MFC on the final allowed cycle still counts as a completion.
                if (bus.ramMFC) begin
                    if (!rw_q) begin
                        rdata_d = bus.ramDataOut;
                    end
                    fdone_d = ~owner_q;
                    ddone_d = owner_q;
                    mfa_d   = 1'b0;
                    fgnt_d  = 1'b0;
                    dgnt_d  = 1'b0;
                    timer_d = 8'd0;
                    state_d = S_DONE;
                end else if (timer_q == c_TMO_LAST) begin
                    if (!rw_q) begin
                        rdata_d = 32'd0;
                    end
                    fdone_d = ~owner_q;
                    ddone_d = owner_q;
                    err_d   = 1'b1;
                    mfa_d   = 1'b0;
                    fgnt_d  = 1'b0;
                    dgnt_d  = 1'b0;
                    timer_d = 8'd0;
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            // Done/busErr pulses are already out; one settling cycle in IDLE
            // follows before the next grant.
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            timer_q <= 8'd0;
            owner_q <= 1'b0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            mfa_q   <= 1'b0;
            fgnt_q  <= 1'b0;
            dgnt_q  <= 1'b0;
            fdone_q <= 1'b0;
            ddone_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mfa_q   <= mfa_d;
            fgnt_q  <= fgnt_d;
            dgnt_q  <= dgnt_d;
            fdone_q <= fdone_d;
            ddone_q <= ddone_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign bus.fetchGnt    = fgnt_q;
    assign bus.dataGnt     = dgnt_q;
    assign bus.fetchDone   = fdone_q;
    assign bus.dataDone    = ddone_q;
    assign bus.busErr      = err_q;
    assign bus.rdata       = rdata_q;
    assign bus.ramMFA      = mfa_q;
    assign bus.ramRW       = rw_q;
    assign bus.ramAddress  = addr_q;
    assign bus.ramDataSize = size_q;
    assign bus.ramDataIn   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Self-checking bench for ram_port_arbiter. Expected
//                transactions are queued as requests are raised; a RAM model
//                answers MFA and checks the presented access, and a monitor
//                pops and compares each completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;
    localparam int TIMEOUT = 16;
    localparam int ADDR_W  = 9;

    logic clk;
    logic resetN;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    ram_port_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) u_dut (
        .Clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        own_data;
        logic        rw;
        logic [8:0]  addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          mfc_delay = 0;      // MFC high in BUSY cycle mfc_delay+1; <0 = never
    int          busy_cnt = 0;
    int          last_len = 0;
    logic [31:0] ram_word = 32'd0;
    logic [31:0] exp_rdata = 32'd0;

    assign bus.ramDataOut = ram_word ^ {23'd0, bus.ramAddress};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic void push_exp(input logic own_data, input logic rw, input logic [1:0] size,
                                     input logic [8:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.own_data = own_data;
        e.rw       = rw;
        e.size     = size;
        e.addr     = addr;
        e.wdata    = wdata;
        if (mfc_delay < 0) begin
            e.err = 1'b1;
            e.len = TIMEOUT;
            if (!rw) exp_rdata = 32'd0;
        end else begin
            e.err = 1'b0;
            e.len = mfc_delay + 1;
            if (!rw) exp_rdata = ram_word ^ {23'd0, addr};
        end
        e.rdata = exp_rdata;
        sb.push_back(e);
    endfunction

    // RAM model: counts MFA cycles, answers with MFC, checks the presented access.
    initial begin
        bus.ramMFC = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ramMFA) begin
                busy_cnt++;
                last_len = busy_cnt;
                if (busy_cnt == 1) begin
                    if (sb.size() == 0) begin
                        check_val("mfa_unexpected", 32'd1, 32'd0);
                    end else begin
                        check_val("ram_addr", 32'(bus.ramAddress), 32'(sb[0].addr));
                        check_val("ram_rw",   32'(bus.ramRW),      32'(sb[0].rw));
                        check_val("ram_size", 32'(bus.ramDataSize), 32'(sb[0].size));
                        if (sb[0].rw) check_val("ram_wdata", bus.ramDataIn, sb[0].wdata);
                        check_val("gnt_owner", {30'd0, bus.fetchGnt, bus.dataGnt},
                                  sb[0].own_data ? 32'd1 : 32'd2);
                    end
                end
                bus.ramMFC = (mfc_delay >= 0) && (busy_cnt == mfc_delay + 1);
            end else begin
                busy_cnt   = 0;
                bus.ramMFC = 1'b0;
            end
        end
    end

    // Completion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetN) begin
                check_val("gnt_overlap", 32'(bus.fetchGnt & bus.dataGnt), 32'd0);
                if (bus.fetchDone || bus.dataDone) begin
                    if (sb.size() == 0) begin
                        check_val("spurious_done", {30'd0, bus.fetchDone, bus.dataDone}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_val("done_owner", {30'd0, bus.fetchDone, bus.dataDone},
                                  e.own_data ? 32'd1 : 32'd2);
                        check_val("bus_err", 32'(bus.busErr), 32'(e.err));
                        check_val("rdata", bus.rdata, e.rdata);
                        check_val("mfa_len", 32'(last_len), 32'(e.len));
                        check_val("gnt_after_done", {30'd0, bus.fetchGnt, bus.dataGnt}, 32'd0);
                    end
                end else begin
                    check_val("err_without_done", 32'(bus.busErr), 32'd0);
                end
            end
        end
    end

    task automatic do_fetch(input logic [8:0] addr);
        bit seen = 0;
        bus.fetchAddr = addr;
        bus.fetchReq  = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.fetchDone) seen = 1;
        end
        if (!seen) check_val("fetch_done_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.fetchReq = 1'b0;
    endtask

    task automatic do_data(input logic rw, input logic [8:0] addr, input logic [31:0] wdata);
        bit seen = 0;
        bus.dataRW    = rw;
        bus.dataSize  = 2'b11;
        bus.dataAddr  = addr;
        bus.dataWdata = wdata;
        bus.dataReq   = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.dataDone) seen = 1;
        end
        if (!seen) check_val("data_done_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.dataReq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN        = 1'b0;
        bus.fetchReq  = 1'b0;
        bus.fetchAddr = '0;
        bus.dataReq   = 1'b0;
        bus.dataRW    = 1'b0;
        bus.dataSize  = 2'b00;
        bus.dataAddr  = '0;
        bus.dataWdata = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst_mfa",   32'(bus.ramMFA), 32'd0);
        check_val("rst_gnt",   {30'd0, bus.fetchGnt, bus.dataGnt}, 32'd0);
        check_val("rst_done",  {29'd0, bus.fetchDone, bus.dataDone, bus.busErr}, 32'd0);
        check_val("rst_rdata", bus.rdata, 32'd0);
        check_val("rst_ram",   {20'd0, bus.ramRW, bus.ramAddress, bus.ramDataSize}, 32'd0);
        check_val("rst_wdata", bus.ramDataIn, 32'd0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        // Single fetch read returning 8C220004 from 0x010.
        mfc_delay = 2;
        ram_word  = 32'h8C220004 ^ 32'h010;
        push_exp(1'b0, 1'b0, 2'b11, 9'h010, 32'd0);
        do_fetch(9'h010);
        check_val("fetch_rdata", bus.rdata, 32'h8C220004);

        // Data write: rdata must be untouched.
        @(negedge clk);
        mfc_delay = 1;
        push_exp(1'b1, 1'b1, 2'b11, 9'h1C0, 32'hDEADBEEF);
        do_data(1'b1, 9'h1C0, 32'hDEADBEEF);

        // Data read with immediate MFC.
        @(negedge clk);
        mfc_delay = 0;
        ram_word  = 32'h12345678;
        push_exp(1'b1, 1'b0, 2'b11, 9'h033, 32'd0);
        do_data(1'b0, 9'h033, 32'd0);

        // Two rounds of simultaneous requests: data then fetch each time.
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            mfc_delay = 1 + r;
            ram_word  = 32'hA5A50000 + 32'(r);
            push_exp(1'b1, 1'b0, 2'b11, 9'h0F0 + 9'(r), 32'd0);
            push_exp(1'b0, 1'b0, 2'b11, 9'h020 + 9'(r), 32'd0);
            fork
                do_data(1'b0, 9'h0F0 + 9'(r), 32'd0);
                do_fetch(9'h020 + 9'(r));
            join
        end

        // Timeout on a read, then a normal fetch.
        @(negedge clk);
        mfc_delay = -1;
        push_exp(1'b1, 1'b0, 2'b11, 9'h055, 32'd0);
        do_data(1'b0, 9'h055, 32'd0);
        check_val("timeout_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        mfc_delay = 3;
        ram_word  = 32'h0BADF00D;
        push_exp(1'b0, 1'b0, 2'b11, 9'h100, 32'd0);
        do_fetch(9'h100);

        // MFC on the last allowed BUSY cycle completes normally.
        @(negedge clk);
        mfc_delay = TIMEOUT - 1;
        ram_word  = 32'hCAFE0000;
        push_exp(1'b1, 1'b0, 2'b11, 9'h1FF, 32'd0);
        do_data(1'b0, 9'h1FF, 32'd0);

        // Asynchronous reset in the middle of a fetch.
        @(negedge clk);
        mfc_delay = -1;
        push_exp(1'b0, 1'b0, 2'b11, 9'h077, 32'd0);
        bus.fetchAddr = 9'h077;
        bus.fetchReq  = 1'b1;
        repeat (3) @(negedge clk);
        check_val("mid_mfa_before", 32'(bus.ramMFA), 32'd1);
        #2 resetN = 1'b0;
        #1;
        check_val("arst_mfa",   32'(bus.ramMFA), 32'd0);
        check_val("arst_gnt",   {30'd0, bus.fetchGnt, bus.dataGnt}, 32'd0);
        check_val("arst_done",  {30'd0, bus.fetchDone, bus.dataDone}, 32'd0);
        check_val("arst_rdata", bus.rdata, 32'd0);
        bus.fetchReq = 1'b0;
        sb.delete();
        @(negedge clk);
        resetN = 1'b1;
        repeat (20) @(negedge clk);
        check_val("post_rst_mfa", 32'(bus.ramMFA), 32'd0);
        check_val("post_rst_gnt", {30'd0, bus.fetchGnt, bus.dataGnt}, 32'd0);
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Arbitrates the single RAM port between the instruction-fetch path (fetch states) and the load/store data path (lw/sw states).
- Drives the RAM MFA/MFC handshake on behalf of the winning requester and returns read data.
- Provides a per-transaction MFC timeout that aborts the access and flags a bus error, so the control unit can take a trap.

Parameters:
- TIMEOUT, 16, max cycles in BUSY waiting for ramMFC before abort; legal range 2..255.
- ADDR_W, 9, RAM address width.

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- resetN  in  1  asynchronous, active-low reset
- fetchReq  in  1  fetch request (level)
- fetchAddr  in  ADDR_W  fetch address
- fetchGnt  out  1  fetch owns port
- fetchDone  out  1  one-cycle completion pulse to fetch
- dataReq  in  1  data request (level)
- dataRW  in  1  1=write, 0=read
- dataSize  in  2  RAM data size code (2'b11=word)
- dataAddr  in  ADDR_W  data address
- dataWdata  in  32  write data
- dataGnt  out  1  data path owns port
- dataDone  out  1  one-cycle completion pulse to data path
- rdata  out  32  read data of last completed read
- busErr  out  1  one-cycle pulse, coincident with done, on timeout
- ramMFA  out  1  memory function active
- ramRW  out  1  RAM direction
- ramAddress  out  ADDR_W  RAM address
- ramDataSize  out  2  RAM size code
- ramDataIn  out  32  write data to RAM
- ramDataOut  in  32  read data from RAM
- ramMFC  in  1  memory function complete

Behaviour:
- Reset (resetN=0, async): state=IDLE; timer=0; all outputs 0 (gnt, done, busErr, ramMFA, ramRW, ramAddress, ramDataSize, ramDataIn, rdata). The in-flight transaction is dropped and not resumed after reset.
- States: IDLE, BUSY, DONE, ERR. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Request present: pick the owner by priority; latch address, rw, size and wdata; set the owner's gnt; go to BUSY.
  - Fetch requests always latch rw=0 and size=2'b11.
  - ramMFC is ignored in IDLE.
- BUSY:
  - ramMFA=1; ramRW, ramAddress, ramDataSize and ramDataIn come from the latched values, stable for the whole state.
  - timer increments each cycle.
  - ramMFC=1: for a read, latch rdata=ramDataOut; go to DONE.
  - Else if timer==TIMEOUT-1: go to ERR.
  - ramMFC in the same cycle as the timeout wins (normal completion).
- DONE: ramMFA=0; owner's done=1 for exactly one cycle; gnt cleared; timer=0; go to IDLE.
- ERR: ramMFA=0; owner's done=1 and busErr=1 for one cycle; rdata=0 on a read; gnt cleared; timer=0; go to IDLE.
- Latency:
  - Request sampled at edge N gives ramMFA=1 in cycle N+1.
  - ramMFC sampled at edge M gives done in cycle M+1 and a new grant no earlier than M+2.
  - Minimum turnaround is 3 cycles per access.
- Requester rules:
  - Hold req and the qualifying inputs stable from assertion until done is sampled.
  - Drop req at the edge that samples done; req still high in IDLE after done starts a new transaction.
  - Arbiter ignores input changes while not in IDLE.
- Priority (default): dataReq beats fetchReq on a simultaneous request, so a load/store is never delayed by a prefetch.
- Writes leave rdata unchanged.
- One owner at a time: fetchGnt and dataGnt are never both 1.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, the requester not granted last wins. A 1-bit lastOwner register (reset to fetch) updates on every grant.
- Undefined: fixed data-over-fetch priority; no lastOwner register.

Test Plan:
- Single fetch read: fetchReq=1, fetchAddr=9'h010, ramMFC asserted 2 cycles after ramMFA, ramDataOut=32'h8C220004 -> ramAddress=9'h010, ramRW=0, ramDataSize=2'b11; fetchDone pulses once; rdata=32'h8C220004; busErr=0; total 5 cycles from req to done.
- Data write: dataReq=1, dataRW=1, dataAddr=9'h1C0, dataWdata=32'hDEADBEEF, ramMFC after 1 cycle -> ramRW=1, ramDataIn=32'hDEADBEEF; dataDone pulses; rdata unchanged.
- Simultaneous fetchReq and dataReq, two back-to-back transactions:
  - Default build: data granted first, fetch second.
  - With RAM_ARB_ROUND_ROBIN_EN, after reset: data granted first (lastOwner=fetch), fetch second; a second simultaneous request then grants data first again.
  - Grants never overlap in either build.
- Timeout: TIMEOUT=16, ramMFC held 0 -> ramMFA high for exactly 16 cycles; then dataDone=1 and busErr=1 in the same cycle; rdata=0; arbiter returns to IDLE and serves the next fetch normally.
- Timeout boundary: ramMFC=1 exactly on the 16th BUSY cycle -> normal DONE, busErr=0, rdata=ramDataOut.
- Reset mid-access: resetN=0 while in BUSY -> ramMFA, gnt, done and rdata go to 0 immediately without waiting for a clock edge; after release with requests low, the arbiter stays in IDLE with no spurious done.
